mem_access_stage: RTL and testbench

//  MEM stage, directly downstream of the EX/MEM latch. Takes the latched ALU result, store data and

---
 rtl/mem_access_stage.sv | 149 ++++++++++++++
 tb/tb_mem_access_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs the load/store handshake with the data cache, freezes upstream
// while a miss is outstanding, and registers the result into the MEM/WB fields.
module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int WSEL_W  = 5,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_aluOut,
  input  logic [DATA_W-1:0] in_rdat2,
  input  logic              in_dMemREN,
  input  logic              in_dMemWEN,
  input  logic              in_MemToReg,
  input  logic              in_regWEN,
  input  logic [WSEL_W-1:0] in_wsel,
  input  logic              in_Halt,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_regWEN,
  output logic [WSEL_W-1:0] wb_wsel,
  output logic [DATA_W-1:0] wb_wdat,
  output logic              halt,
  output logic              align_err,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

  state_t            state_reg, state_next;
  logic [WC_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic              wb_valid_reg, wb_regwen_reg;
  logic [WSEL_W-1:0] wb_wsel_reg;
  logic [DATA_W-1:0] wb_wdat_reg;
  logic              halt_reg, align_err_reg, timeout_err_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic mem_req, aligned, memop, misaligned, timeout_hit;
  logic req, stall_int, capture, drop;

  assign aligned     = (in_aluOut[1:0] == 2'b00);
  assign mem_req     = in_valid & (in_dMemREN | in_dMemWEN) & ~halt_reg;
  assign memop       = mem_req & aligned;
  assign misaligned  = mem_req & ~aligned;
  assign timeout_hit = (state_reg == WAIT) & ~dhit & (wait_cnt_reg == WC_LAST);

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    req           = 1'b0;
    stall_int     = 1'b0;
    capture       = 1'b0;
    drop          = 1'b0;
    case (state_reg)
      IDLE: begin
        req = memop;
        if (memop && !dhit) begin
          stall_int     = 1'b1;
          state_next    = WAIT;
          wait_cnt_next = '0;
        end else begin
          capture = in_valid;
          drop    = misaligned;
        end
      end
      WAIT: begin
        // Upstream is frozen, so the request inputs are still those of the missing instruction.
        if (dhit) begin
          req        = 1'b1;
          capture    = in_valid;
          state_next = IDLE;
        end else if (timeout_hit) begin
          capture    = in_valid;
          drop       = 1'b1;
          state_next = IDLE;
        end else begin
          req           = 1'b1;
          stall_int     = 1'b1;
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: state_next = IDLE;
    endcase
    if (capture && in_Halt) state_next = HALTED;
  end

  // Requests and stall are masked by RST so an outstanding miss drops the instant reset rises.
  assign dmemREN   = req & in_dMemREN & ~RST;
  assign dmemWEN   = req & in_dMemWEN & ~in_dMemREN & ~RST;
  assign stall     = stall_int & ~RST;
  assign dmemaddr  = in_aluOut;
  assign dmemstore = in_rdat2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= '0;
      wb_valid_reg    <= 1'b0;
      wb_regwen_reg   <= 1'b0;
      wb_wsel_reg     <= '0;
      wb_wdat_reg     <= '0;
      halt_reg        <= 1'b0;
      align_err_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
      stall_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (capture) begin
        wb_valid_reg  <= 1'b1;
        wb_regwen_reg <= in_regWEN & ~drop;
        wb_wsel_reg   <= in_wsel;
        wb_wdat_reg   <= in_MemToReg ? dmemload : in_aluOut;
        halt_reg      <= halt_reg | in_Halt;
      end else begin
        wb_valid_reg  <= 1'b0;
        wb_regwen_reg <= 1'b0;
      end
      if (capture && drop && state_reg == IDLE) align_err_reg <= 1'b1;
      if (timeout_hit) timeout_err_reg <= 1'b1;
      if (stall_int && stall_cnt_reg != {CNT_W{1'b1}}) stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign wb_valid    = wb_valid_reg;
  assign wb_regWEN   = wb_regwen_reg;
  assign wb_wsel     = wb_wsel_reg;
  assign wb_wdat     = wb_wdat_reg;
  assign halt        = halt_reg;
  assign align_err   = align_err_reg;
  assign timeout_err = timeout_err_reg;
  assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected MEM/WB writes are queued as stimulus is
// driven and popped whenever the stage presents wb_valid.
module tb_mem_access_stage;

  localparam int DATA_W  = 32;
  localparam int WSEL_W  = 5;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic              in_valid, in_dMemREN, in_dMemWEN, in_MemToReg, in_regWEN, in_Halt;
  logic [DATA_W-1:0] in_aluOut, in_rdat2, dmemload;
  logic [WSEL_W-1:0] in_wsel;
  logic              dhit;
  logic              dmemREN, dmemWEN, stall, wb_valid, wb_regWEN, halt, align_err, timeout_err;
  logic [DATA_W-1:0] dmemaddr, dmemstore, wb_wdat;
  logic [WSEL_W-1:0] wb_wsel;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct packed {
    logic [WSEL_W-1:0] wsel;
    logic              regwen;
    logic [DATA_W-1:0] wdat;
  } wb_t;

  wb_t exp_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  mem_access_stage #(.DATA_W(DATA_W), .WSEL_W(WSEL_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_aluOut(in_aluOut), .in_rdat2(in_rdat2),
    .in_dMemREN(in_dMemREN), .in_dMemWEN(in_dMemWEN), .in_MemToReg(in_MemToReg),
    .in_regWEN(in_regWEN), .in_wsel(in_wsel), .in_Halt(in_Halt), .dhit(dhit),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .stall(stall), .wb_valid(wb_valid), .wb_regWEN(wb_regWEN),
    .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .halt(halt), .align_err(align_err),
    .timeout_err(timeout_err), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] st,
                       input logic ren, input logic wen, input logic m2r, input logic rwen,
                       input logic [4:0] ws, input logic hlt);
    in_valid = v; in_aluOut = alu; in_rdat2 = st; in_dMemREN = ren; in_dMemWEN = wen;
    in_MemToReg = m2r; in_regWEN = rwen; in_wsel = ws; in_Halt = hlt;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    dhit = 1'b0;
  endtask

  task automatic push(input logic [4:0] ws, input logic rw, input logic [31:0] wd);
    wb_t e;
    e.wsel = ws; e.regwen = rw; e.wdat = wd;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then score whatever MEM/WB now holds.
  task automatic tick();
    wb_t e;
    @(posedge CLK);
    #1;
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_wb", 64'(wb_wsel), 64'h3f);
      end else begin
        e = exp_q.pop_front();
        chk("sb_wsel", 64'(wb_wsel), 64'(e.wsel));
        chk("sb_regwen", 64'(wb_regWEN), 64'(e.regwen));
        chk("sb_wdat", 64'(wb_wdat), 64'(e.wdat));
        $display("wb: wsel=%0d regWEN=%0b wdat=%08h", wb_wsel, wb_regWEN, wb_wdat);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    idle();
    dmemload = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_wb_valid", 64'(wb_valid), 64'h0);
    chk("rst_halt", 64'(halt), 64'h0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    RST = 1'b0;
    tick();

    // T1: plain ALU op
    drive(1'b1, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    #1;
    chk("t1_stall", 64'(stall), 64'h0);
    chk("t1_ren", 64'(dmemREN), 64'h0);
    push(5'd5, 1'b1, 32'h1234);
    tick();
    chk("t1_wb_valid", 64'(wb_valid), 64'h1);
    idle();

    // T2: load hit, zero stall
    drive(1'b1, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    dhit = 1'b1; dmemload = 32'hDEADBEEF;
    #1;
    chk("t2_stall", 64'(stall), 64'h0);
    chk("t2_ren", 64'(dmemREN), 64'h1);
    chk("t2_addr", 64'(dmemaddr), 64'h100);
    push(5'd7, 1'b1, 32'hDEADBEEF);
    tick();
    idle();

    // T3: store miss, hit after three stall cycles
    drive(1'b1, 32'h200, 32'hCAFE, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0);
    push(5'd3, 1'b0, 32'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall", 64'(stall), 64'h1);
      chk("t3_wen", 64'(dmemWEN), 64'h1);
      chk("t3_store", 64'(dmemstore), 64'hCAFE);
      tick();
    end
    dhit = 1'b1;
    #1;
    chk("t3_stall_on_hit", 64'(stall), 64'h0);
    chk("t3_wen_on_hit", 64'(dmemWEN), 64'h1);
    tick();
    idle();
    chk("t3_stall_cnt", 64'(stall_cnt), 64'd3);

    // T4: misaligned load is dropped
    drive(1'b1, 32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
    dmemload = 32'h11111111;
    #1;
    chk("t4_ren", 64'(dmemREN), 64'h0);
    chk("t4_stall", 64'(stall), 64'h0);
    push(5'd9, 1'b0, 32'h11111111);
    tick();
    idle();
    chk("t4_align_err", 64'(align_err), 64'h1);

    // T5: timeout with dhit held low
    drive(1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
    dmemload = 32'h0000ABCD;
    push(5'd4, 1'b0, 32'h0000ABCD);
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      chk("t5_stall", 64'(stall), 64'h1);
      chk("t5_ren", 64'(dmemREN), 64'h1);
      tick();
    end
    #1;
    chk("t5_stall_end", 64'(stall), 64'h0);
    chk("t5_ren_drop", 64'(dmemREN), 64'h0);
    tick();
    idle();
    chk("t5_timeout_err", 64'(timeout_err), 64'h1);
    chk("t5_stall_cnt", 64'(stall_cnt), 64'd11);
    drive(1'b1, 32'h42, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
    #1;
    chk("t5_idle_again", 64'(stall), 64'h0);
    push(5'd6, 1'b1, 32'h42);
    tick();
    idle();

    // Load and store together: the load wins
    drive(1'b1, 32'h600, 32'h77, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
    dhit = 1'b1; dmemload = 32'h99;
    #1;
    chk("both_wen", 64'(dmemWEN), 64'h0);
    chk("both_ren", 64'(dmemREN), 64'h1);
    push(5'd8, 1'b1, 32'h99);
    tick();
    idle();

    // T6: halt, then a load that must not be issued
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    push(5'd0, 1'b0, 32'h0);
    tick();
    idle();
    chk("t6_halt", 64'(halt), 64'h1);
    drive(1'b1, 32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
    #1;
    chk("t6_ren_after_halt", 64'(dmemREN), 64'h0);
    chk("t6_stall_after_halt", 64'(stall), 64'h0);
    tick();
    chk("t6_wb_valid_halted", 64'(wb_valid), 64'h0);
    idle();
    tick();
    chk("t6_halt_sticky", 64'(halt), 64'h1);

    // Reset mid-cycle clears sticky state asynchronously
    #2;
    RST = 1'b1;
    #1;
    chk("t6_rst_halt", 64'(halt), 64'h0);
    chk("t6_rst_align", 64'(align_err), 64'h0);
    chk("t6_rst_timeout", 64'(timeout_err), 64'h0);
    chk("t6_rst_stall_cnt", 64'(stall_cnt), 64'h0);
    RST = 1'b0;
    tick();

    // Reset during WAIT drops the request immediately
    drive(1'b1, 32'h500, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0);
    tick();
    tick();
    #1;
    chk("t6_wait_ren", 64'(dmemREN), 64'h1);
    chk("t6_wait_stall_cnt", 64'(stall_cnt), 64'd2);
    RST = 1'b1;
    #1;
    chk("t6_rst_ren", 64'(dmemREN), 64'h0);
    chk("t6_rst_stall", 64'(stall), 64'h0);
    chk("t6_rst_cnt_wait", 64'(stall_cnt), 64'h0);
    idle();
    tick();
    RST = 1'b0;
    tick();
    chk("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
